// File: rtl/excpt_ctrl_if.sv
// Bus between the commit stage and the exception controller.
// The slave modport is the controller side.
interface excpt_ctrl_if #(
    parameter int unsigned N_IRQ  = 6,
    parameter int unsigned ADDR_W = 32
);
    logic [N_IRQ-1:0]  irq;
    logic [31:0]       excptype;
    logic              inst_valid;
    logic [ADDR_W-1:0] inst_pc;
    logic              im_wr;
    logic [N_IRQ-1:0]  im_wdata;
    logic              excpt;
    logic [ADDR_W-1:0] ejpc;
    logic [ADDR_W-1:0] epc;
    logic [4:0]        cause_code;
    logic [2:0]        cause_irq;
    logic              in_handler;
    logic [N_IRQ-1:0]  pending;

    modport slave (
        input  irq, excptype, inst_valid, inst_pc, im_wr, im_wdata,
        output excpt, ejpc, epc, cause_code, cause_irq, in_handler, pending
    );

    modport master (
        output irq, excptype, inst_valid, inst_pc, im_wr, im_wdata,
        input  excpt, ejpc, epc, cause_code, cause_irq, in_handler, pending
    );
endinterface

// File: rtl/excpt_ctrl.sv
// Registered exception/interrupt controller beside the commit stage:
// edge-latched pending IRQs with mask and fixed priority, EPC/cause, EXL state.
module excpt_ctrl #(
    parameter int unsigned N_IRQ      = 6,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0040,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0010,
    parameter int unsigned ADDR_W     = 32
) (
    input logic          clk,
    input logic          rst,
    excpt_ctrl_if.slave  bus
);
    typedef enum logic {IDLE, HANDLER} state_t;

    state_t            state_q;
    logic [N_IRQ-1:0]  irq_d_q;
    logic [N_IRQ-1:0]  pending_q, pending_d;
    logic [N_IRQ-1:0]  mask_q;
    logic              excpt_q;
    logic [ADDR_W-1:0] ejpc_q;
    logic [ADDR_W-1:0] epc_q;
    logic [4:0]        cause_code_q;
    logic [2:0]        cause_irq_q;

    logic [N_IRQ-1:0]  rise;
    logic [N_IRQ-1:0]  masked;
    logic              irq_hit;
    logic [2:0]        irq_idx;
    logic [N_IRQ-1:0]  clr_vec;
    logic              take_eret, take_sys, take_irq;
    logic [ADDR_W-1:0] irq_vec;
    logic              unused_excptype;

    assign unused_excptype = ^{bus.excptype[31:10], bus.excptype[7:0]};

    always_comb begin
        rise    = bus.irq & ~irq_d_q;
        masked  = pending_q & mask_q;
        irq_hit = 1'b0;
        irq_idx = '0;
        // Scan downwards so the lowest set index is the one left standing.
        for (int unsigned i = N_IRQ; i > 0; i--) begin
            if (masked[i-1]) begin
                irq_hit = 1'b1;
                irq_idx = 3'(i - 1);
            end
        end

        take_eret = bus.inst_valid && bus.excptype[9] && (state_q == HANDLER);
        take_sys  = bus.inst_valid && bus.excptype[8] && (state_q == IDLE);
        take_irq  = bus.inst_valid && !take_sys && irq_hit && (state_q == IDLE);

        irq_vec   = ADDR_W'(VEC_BASE + VEC_STRIDE * (32'(irq_idx) + 32'd1));
        clr_vec   = take_irq ? (N_IRQ'(1) << irq_idx) : '0;
        // A new rising edge wins over the clear of the interrupt being taken.
        pending_d = (pending_q & ~clr_vec) | rise;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            irq_d_q      <= '0;
            pending_q    <= '0;
            mask_q       <= '1;
            excpt_q      <= 1'b0;
            ejpc_q       <= '0;
            epc_q        <= '0;
            cause_code_q <= '0;
            cause_irq_q  <= '0;
        end else begin
            irq_d_q   <= bus.irq;
            pending_q <= pending_d;
            excpt_q   <= 1'b0;
            if (bus.im_wr) begin
                mask_q <= bus.im_wdata;
            end
            if (take_eret) begin
                excpt_q <= 1'b1;
                ejpc_q  <= epc_q;
                state_q <= IDLE;
            end else if (take_sys) begin
                excpt_q      <= 1'b1;
                ejpc_q       <= ADDR_W'(VEC_BASE);
                epc_q        <= bus.inst_pc + ADDR_W'(4);
                cause_code_q <= 5'd8;
                state_q      <= HANDLER;
            end else if (take_irq) begin
                excpt_q      <= 1'b1;
                ejpc_q       <= irq_vec;
                epc_q        <= bus.inst_pc;
                cause_code_q <= 5'd0;
                cause_irq_q  <= irq_idx;
                state_q      <= HANDLER;
            end
        end
    end

    assign bus.excpt      = excpt_q;
    assign bus.ejpc       = ejpc_q;
    assign bus.epc        = epc_q;
    assign bus.cause_code = cause_code_q;
    assign bus.cause_irq  = cause_irq_q;
    assign bus.in_handler = (state_q == HANDLER);
    assign bus.pending    = pending_q;
endmodule
